// File: rtl/uart_tx_dev_pkg.sv
// uart_tx_dev_pkg: register map, bit positions and FSM encoding shared by the UART transmitter slice.
package uart_tx_dev_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_DIV = 2'd3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;
  localparam int CTRL_PEN = 2;
  localparam int ST_FULL = 5;
  localparam int ST_EMPTY = 6;
  localparam int ST_BUSY = 7;
  localparam int ST_OVF = 8;
  localparam int ST_DONE = 9;
  localparam int HWINT_IDX = 3;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
endpackage

// File: rtl/uart_tx_dev_if.sv
// uart_tx_dev_if: bridge device bus toward the UART, plus its interrupt line back to the CPU.
interface uart_tx_dev_if;
  logic [1:0] dev_addr;
  logic we;
  logic [31:0] dev_wd;
  logic [31:0] dev_rd;
  logic irq;
  modport master(output dev_addr, we, dev_wd, input dev_rd, irq);
  modport slave(input dev_addr, we, dev_wd, output dev_rd, irq);
endinterface

// File: rtl/uart_tx_dev_sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through head; full is judged before a same-cycle pop.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 transmitter with FIFO and drain interrupt (HWInt 3); UART_PARITY_EN adds even parity.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RST = 16'd16
) (
  input  logic clk,
  input  logic rst,
  uart_tx_dev_if.slave bus,
  output logic txd
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, nstate;
  logic en, ie, pen, ovf, done, irq_q, par, pop, done_set, ie_n, done_n, bit_end, unused;
  logic wr_ctrl, wr_stat, wr_data, wr_div, f_full, f_empty;
  logic [CW-1:0] f_count;
  logic [7:0] f_dout, sh;
  logic [15:0] div, div_eff, div_lat, cnt;
  logic [2:0] idx;
  assign wr_ctrl = bus.we && bus.dev_addr == REG_CTRL;
  assign wr_stat = bus.we && bus.dev_addr == REG_STATUS;
  assign wr_data = bus.we && bus.dev_addr == REG_DATA;
  assign wr_div = bus.we && bus.dev_addr == REG_DIV;
  assign div_eff = div == '0 ? 16'd1 : div;
  assign bit_end = cnt == 16'd1;
  assign bus.irq = irq_q;
  assign unused = ^bus.dev_wd[31:16];
  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk), .rst(rst), .push(wr_data), .din(bus.dev_wd[7:0]), .pop(pop),
    .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_count)
  );
  assign bus.dev_rd = bus.dev_addr == REG_CTRL ? {29'd0, pen, ie, en} :
                      bus.dev_addr == REG_STATUS ? {22'd0, done, ovf, state != S_IDLE, f_empty, f_full, 5'(f_count)} :
                      bus.dev_addr == REG_DIV ? {16'd0, div} : 32'd0;
`ifdef UART_PARITY_EN
  always_ff @(posedge clk)
    if (rst) pen <= 1'b0;
    else if (wr_ctrl) pen <= bus.dev_wd[CTRL_PEN];
`else
  assign pen = 1'b0;
`endif
  always_comb begin
    nstate = state;
    pop = 1'b0;
    case (state)
      S_IDLE: if (en && !f_empty) begin
        nstate = S_START;
        pop = 1'b1;
      end
      S_START: if (bit_end) nstate = S_DATA;
      S_DATA: if (bit_end && idx == 3'd7) nstate = pen ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) nstate = S_STOP;
      S_STOP: if (bit_end) begin
        nstate = en && !f_empty ? S_START : S_IDLE;
        pop = en && !f_empty;
      end
      default: nstate = S_IDLE;
    endcase
  end
  // irq tracks the post-edge DONE/IE so a STATUS write drops it on the following cycle
  always_comb begin
    done_set = state == S_STOP && bit_end && f_empty;
    ie_n = wr_ctrl ? bus.dev_wd[CTRL_IE] : ie;
    done_n = done_set | (done & ~wr_stat);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      en <= 1'b0;
      ie <= 1'b0;
      ovf <= 1'b0;
      done <= 1'b0;
      irq_q <= 1'b0;
      txd <= 1'b1;
      div <= DIV_RST;
      div_lat <= DIV_RST;
      cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      idx <= '0;
    end else begin
      state <= nstate;
      ie <= ie_n;
      done <= done_n;
      irq_q <= done_n & ie_n;
      ovf <= (ovf & ~wr_stat) | (wr_data & f_full);
      if (wr_ctrl) en <= bus.dev_wd[CTRL_EN];
      if (wr_div) div <= bus.dev_wd[15:0];
      if (pop) begin
        sh <= f_dout;
        par <= ^f_dout;
        div_lat <= div_eff;
        cnt <= div_eff;
        idx <= '0;
      end else if (state != S_IDLE) begin
        cnt <= bit_end ? div_lat : cnt - 16'd1;
        if (state == S_DATA && bit_end) begin
          sh <= sh >> 1;
          idx <= idx + 3'd1;
        end
      end
      txd <= state == S_START ? 1'b0 : state == S_DATA ? sh[0] : state == S_PARITY ? par : 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: directed register/frame stimulus with a queued-frame scoreboard decoding txd.
module tb_uart_tx_dev;
  import uart_tx_dev_pkg::*;
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  typedef struct {
    logic [7:0] data;
    int div;
    bit b2b;
    bit cut;
    bit p;
  } frame_t;
  logic clk = 1'b0, rst = 1'b1, txd;
  int checks = 0, errors = 0, cyc = 0, le = 0;
  bit mon_busy = 1'b0;
  frame_t exp_q[$];
  uart_tx_dev_if bus();
  uart_tx_dev #(.FIFO_DEPTH(8), .DIV_RST(16'd16)) dut (.clk(clk), .rst(rst), .bus(bus.slave), .txd(txd));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.dev_addr = a;
    bus.dev_wd = d;
    bus.we = 1'b1;
    @(posedge clk);
    #1 bus.we = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    bus.dev_addr = a;
    #1 chk(nm, bus.dev_rd, exp);
  endtask
  task automatic drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      ok = exp_q.size() == 0 && !mon_busy;
      if (!ok) tick(1);
    end
    chk(nm, ok, 1'b1);
    tick(2);
  endtask
  initial begin : mon
    frame_t e;
    logic [10:0] bits;
    int n;
    bit ok, ab;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1'b1, 1'b0);
          for (int i = 0; i < 400 && txd !== 1'b1; i++) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          if (e.b2b) chk("frame_gap", cyc - le, 1);
          n = e.p ? 11 : 10;
          bits = '1;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = e.data[i];
          if (e.p) bits[9] = ^e.data;
          ab = 1'b0;
          for (int b = 0; b < n && !ab; b++) begin
            ok = 1'b1;
            for (int c = 0; c < e.div && !ab; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst) ab = 1'b1;
              else if (txd !== bits[b]) ok = 1'b0;
            end
            if (!ab) chk($sformatf("frame_%02h_bit%0d", e.data, b), ok, 1'b1);
          end
          chk($sformatf("frame_%02h_cut", e.data), ab, e.cut);
        end
        le = cyc;
        mon_busy = 1'b0;
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [7:0] bytes [9] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h3C, 8'h96, 8'h77};
    bus.dev_addr = 2'd0;
    bus.dev_wd = 32'd0;
    bus.we = 1'b0;
    tick(3);
    rst = 1'b0;
    rd(REG_CTRL, 32'h0, "rst_ctrl");
    rd(REG_STATUS, 32'h40, "rst_status");
    rd(REG_DATA, 32'h0, "rst_data");
    rd(REG_DIV, 32'h10, "rst_div");
    chk("rst_txd", txd, 1'b1);
    chk("rst_irq", bus.irq, 1'b0);
    wr(REG_DIV, 32'd4);
    wr(REG_CTRL, 32'd1);
    exp_q.push_back('{8'hA5, 4, 1'b0, 1'b0, 1'b0});
    wr(REG_DATA, 32'hA5);
    drain("drain_a5");
    rd(REG_STATUS, 32'h240, "done_status");
    chk("irq_ie0", bus.irq, 1'b0);
    wr(REG_STATUS, 32'd0);
    wr(REG_CTRL, 32'd0);
    for (int i = 0; i < 9; i++) wr(REG_DATA, {24'd0, bytes[i]});
    rd(REG_STATUS, 32'h128, "full_ovf_status");
    for (int i = 0; i < 8; i++) exp_q.push_back('{bytes[i], 4, i != 0, 1'b0, 1'b0});
    wr(REG_CTRL, 32'd3);
    tick(20);
    chk("irq_midrun", bus.irq, 1'b0);
    drain("drain_burst");
    chk("irq_after_burst", bus.irq, 1'b1);
    rd(REG_STATUS, 32'h340, "burst_status");
    wr(REG_STATUS, 32'd0);
    chk("irq_cleared", bus.irq, 1'b0);
    rd(REG_STATUS, 32'h40, "cleared_status");
    wr(REG_CTRL, 32'd0);
    wr(REG_DATA, 32'h3C);
    exp_q.push_back('{8'h3C, 4, 1'b0, 1'b0, 1'b0});
    exp_q.push_back('{8'hC3, 8, 1'b1, 1'b0, 1'b0});
    wr(REG_CTRL, 32'd1);
    wr(REG_DATA, 32'hC3);
    rd(REG_STATUS, 32'h81, "pushpop_status");
    wr(REG_DIV, 32'd8);
    rd(REG_DIV, 32'd8, "div_mid");
    drain("drain_div");
    rd(REG_STATUS, 32'h240, "div_status");
    wr(REG_DIV, 32'd4);
    wr(REG_STATUS, 32'd0);
    wr(REG_CTRL, 32'd0);
    wr(REG_DATA, 32'h55);
    wr(REG_DATA, 32'hAA);
    exp_q.push_back('{8'h55, 4, 1'b0, 1'b1, 1'b0});
    wr(REG_CTRL, 32'd1);
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_mid_txd", txd, 1'b1);
    rd(REG_STATUS, 32'h40, "rst_mid_status");
    rd(REG_CTRL, 32'h0, "rst_mid_ctrl");
    rd(REG_DIV, 32'h10, "rst_mid_div");
    wr(REG_CTRL, 32'd1);
    tick(60);
    chk("rst_discard_txd", txd, 1'b1);
    rd(REG_STATUS, 32'h40, "rst_discard_status");
    wr(REG_DIV, 32'd4);
    wr(REG_CTRL, 32'd5);
    rd(REG_CTRL, {29'd0, PAR, 2'b01}, "pen_ctrl");
    exp_q.push_back('{8'h07, 4, 1'b0, 1'b0, PAR});
    wr(REG_DATA, 32'h07);
    drain("drain_pen");
    wr(REG_CTRL, 32'd1);
    exp_q.push_back('{8'h07, 4, 1'b0, 1'b0, 1'b0});
    wr(REG_DATA, 32'h07);
    drain("drain_nopen");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
